// File: rtl/timer_pkg.sv
// Shared types and default sizing for the multi-channel timer.
package timer_pkg;

   localparam int DEF_WIDTH          = 16;
   localparam int DEF_CHANNELS       = 4;
   localparam int DEF_PRESCALE_WIDTH = 8;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One down-count channel: load/restart, one-shot or auto-reload, sticky done, expiry pulse.
// All outputs registered; load is visible one cycle after its edge.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_preset,
   input  logic             i_auto_reload,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_count,
   output logic             o_done,
   output logic             o_expire
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   ch_state_t        r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload_val;
   logic             r_done;
   logic             r_expire;

   ch_state_t        w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_done_nxt;
   logic             w_expire_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= CH_IDLE;
         r_count      <= '0;
         r_reload_val <= '0;
         r_done       <= 1'b0;
         r_expire     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_reload_val <= w_reload_nxt;
         r_done       <= w_done_nxt;
         r_expire     <= w_expire_nxt;
      end
   end

   // Load wins over a same-cycle tick, so a reload can never be lost to an expiry.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload_val;
      w_done_nxt   = r_done;
      w_expire_nxt = 1'b0;
      if (i_load) begin
         w_count_nxt  = i_preset;
         w_reload_nxt = i_preset;
         w_done_nxt   = 1'b0;
         w_state_nxt  = CH_RUN;
      end else if ((r_state == CH_RUN) && i_tick && i_enable) begin
         if (r_count != '0) begin
            w_count_nxt = r_count - CNT_ONE;
         end else begin
            w_expire_nxt = 1'b1;
            if (i_auto_reload) begin
               w_count_nxt = r_reload_val;
            end else begin
               w_done_nxt  = 1'b1;
               w_state_nxt = CH_IDLE;
            end
         end
      end
   end

   assign o_count  = r_count;
   assign o_done   = r_done;
   assign o_expire = r_expire;

endmodule

// File: rtl/multi_timer.sv
// CHANNELS independent down-counters sharing one programmable tick prescaler.
// Tick every prescale+1 cycles; expiry N+1 ticks after a load of preset N.
module multi_timer
   import timer_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int CHANNELS       = DEF_CHANNELS,
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] preset,
   input  logic [CHANNELS-1:0]       auto_reload,
   input  logic [CHANNELS-1:0]       enable,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       expire
);

   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

   logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
   logic                      w_tick;

   // >= rather than == so lowering prescale below the running count ticks at once.
   assign w_tick = (r_pre_cnt >= prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt <= '0;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + PRE_ONE;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_tick        (w_tick),
         .i_load        (load[g]),
         .i_preset      (preset[g*WIDTH +: WIDTH]),
         .i_auto_reload (auto_reload[g]),
         .i_enable      (enable[g]),
         .o_count       (count[g*WIDTH +: WIDTH]),
         .o_done        (done[g]),
         .o_expire      (expire[g])
      );
   end

endmodule

// File: tb/tb_multi_timer.sv
// Directed and randomized checks of multi_timer against a behavioural model.
module tb_multi_timer;

   localparam int W  = 16;
   localparam int CH = 4;
   localparam int PW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [PW-1:0]   prescale;
   logic [CH-1:0]   load;
   logic [CH*W-1:0] preset;
   logic [CH-1:0]   auto_reload;
   logic [CH-1:0]   enable;
   logic [CH*W-1:0] count;
   logic [CH-1:0]   done;
   logic [CH-1:0]   expire;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: tick phase plus per-channel remaining count, reload, running and flags.
   int m_pre;
   int m_cnt [CH];
   int m_rel [CH];
   bit m_run [CH];
   bit m_done[CH];
   bit m_exp [CH];

   multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prescale    (prescale),
      .load        (load),
      .preset      (preset),
      .auto_reload (auto_reload),
      .enable      (enable),
      .count       (count),
      .done        (done),
      .expire      (expire)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_pre = 0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_done[i] = 0; m_exp[i] = 0;
      end
   endfunction

   function automatic void model_edge();
      bit tk;
      tk    = (m_pre >= int'(prescale));
      m_pre = tk ? 0 : m_pre + 1;
      for (int i = 0; i < CH; i++) begin
         m_exp[i] = 0;
         if (load[i]) begin
            m_cnt[i]  = int'(preset[i*W +: W]);
            m_rel[i]  = m_cnt[i];
            m_done[i] = 0;
            m_run[i]  = 1;
         end else if (m_run[i] && tk && enable[i]) begin
            if (m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
            end else begin
               m_exp[i] = 1;
               if (auto_reload[i]) begin
                  m_cnt[i] = m_rel[i];
               end else begin
                  m_done[i] = 1;
                  m_run[i]  = 0;
               end
            end
         end
      end
   endfunction

   task automatic check_model();
      logic [CH*W-1:0] ec;
      logic [CH-1:0]   ed;
      logic [CH-1:0]   ee;
      for (int i = 0; i < CH; i++) begin
         ec[i*W +: W] = W'(m_cnt[i]);
         ed[i]        = m_done[i];
         ee[i]        = m_exp[i];
      end
      chk("model_count", 64'(count), 64'(ec));
      chk("model_done", 64'(done), 64'(ed));
      chk("model_expire", 64'(expire), 64'(ee));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic set_preset(input int ch, input int v);
      preset[ch*W +: W] = W'(v);
   endtask

   initial begin
      int w;
      int gap;
      int ps;
      int lo;
      int hi;
      int n[CH];
      int e[CH];
      bit all_seen;

      rst_n       = 1'b0;
      prescale    = '0;
      load        = '0;
      preset      = '0;
      auto_reload = '0;
      enable      = '1;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_expire", 64'(expire), 64'd0);
      #3 rst_n = 1'b1;

      // One-shot basic timing, prescale 0, preset 5
      set_preset(0, 5);
      load[0] = 1'b1;
      cyc();
      load = '0;
      chk("t1_count", 64'(count[0 +: W]), 64'd5);
      for (int j = 1; j <= 5; j++) begin
         cyc();
         chk("t1_count", 64'(count[0 +: W]), 64'(5 - j));
         chk("t1_no_expire", 64'(expire[0]), 64'd0);
      end
      cyc();
      chk("t1_expire", 64'(expire[0]), 64'd1);
      chk("t1_done", 64'(done[0]), 64'd1);
      repeat (3) begin
         cyc();
         chk("t1_expire_once", 64'(expire[0]), 64'd0);
         chk("t1_done_sticky", 64'(done[0]), 64'd1);
         chk("t1_count_zero", 64'(count[0 +: W]), 64'd0);
      end

      // Auto-reload period: preset 3, prescale 2 -> 12 cycles
      prescale       = 8'd2;
      auto_reload[1] = 1'b1;
      set_preset(1, 3);
      load[1] = 1'b1;
      cyc();
      load = '0;
      w = 0;
      while (!expire[1] && w < 40) begin
         cyc();
         w++;
      end
      chk("t2_first_expire", 64'(expire[1]), 64'd1);
      for (int p = 0; p < 3; p++) begin
         gap = 0;
         do begin
            cyc();
            gap++;
            chk("t2_done_low", 64'(done[1]), 64'd0);
         end while (!expire[1] && gap < 30);
         chk("t2_period", 64'(gap), 64'd12);
      end
      auto_reload[1] = 1'b0;

      // Enable gating: freeze at 6 for 7 cycles
      prescale = 8'd0;
      set_preset(2, 10);
      load[2] = 1'b1;
      cyc();
      load = '0;
      repeat (4) cyc();
      chk("t3_count6", 64'(count[2*W +: W]), 64'd6);
      enable[2] = 1'b0;
      repeat (7) begin
         cyc();
         chk("t3_hold", 64'(count[2*W +: W]), 64'd6);
         chk("t3_no_expire", 64'(expire[2]), 64'd0);
      end
      enable[2] = 1'b1;
      w = 0;
      do begin
         cyc();
         w++;
      end while (!expire[2] && w < 30);
      chk("t3_delay", 64'(w), 64'd7);
      chk("t3_done", 64'(done[2]), 64'd1);

      // Load priority over a same-cycle expiry
      set_preset(0, 2);
      load[0] = 1'b1;
      cyc();
      load = '0;
      cyc();
      cyc();
      chk("t4_count0_zero", 64'(count[0 +: W]), 64'd0);
      set_preset(0, 4);
      load[0] = 1'b1;
      cyc();
      load = '0;
      chk("t4_no_expire", 64'(expire[0]), 64'd0);
      chk("t4_count4", 64'(count[0 +: W]), 64'd4);
      chk("t4_done_low", 64'(done[0]), 64'd0);

      // Preset 0 one-shot expires on the first tick
      set_preset(3, 0);
      load[3] = 1'b1;
      cyc();
      load = '0;
      chk("t4_ch3_idle_expire", 64'(expire[3]), 64'd0);
      cyc();
      chk("t4_ch3_expire", 64'(expire[3]), 64'd1);
      chk("t4_ch3_done", 64'(done[3]), 64'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         load = '0;
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 19) == 0) begin
               load[i] = 1'b1;
               set_preset(i, int'($urandom_range(0, 12)));
            end
            enable[i] = ($urandom_range(0, 5) != 0);
         end
         if ($urandom_range(0, 7) == 0) auto_reload = CH'($urandom);
         if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
         cyc();
      end
      load        = '0;
      enable      = '1;
      auto_reload = '0;

      // Independence: distinct presets, spacing set by prescale
      ps       = int'($urandom_range(1, 3));
      prescale = PW'(ps);
      for (int i = 0; i < CH; i++) begin
         n[i] = 3 + 4 * i + int'($urandom_range(0, 3));
         e[i] = -1;
         set_preset(i, n[i]);
      end
      load = '1;
      cyc();
      load = '0;
      all_seen = 0;
      for (int c = 0; c < 120 && !all_seen; c++) begin
         cyc();
         all_seen = 1;
         for (int i = 0; i < CH; i++) begin
            if (expire[i] && e[i] < 0) e[i] = c;
            if (e[i] < 0) all_seen = 0;
         end
      end
      chk("t5_all_expired", 64'(all_seen), 64'd1);
      lo = n[0] * (ps + 1);
      hi = lo + ps;
      chk("t5_first_window", 64'(e[0] >= lo && e[0] <= hi), 64'd1);
      for (int i = 1; i < CH; i++) begin
         chk("t5_spacing", 64'(e[i] - e[0]), 64'((n[i] - n[0]) * (ps + 1)));
      end

      // Asynchronous reset mid-count
      for (int i = 0; i < CH; i++) set_preset(i, 50 + i);
      load = '1;
      cyc();
      load = '0;
      repeat (10) cyc();
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_count", 64'(count), 64'd0);
      chk("t6_async_done", 64'(done), 64'd0);
      chk("t6_async_expire", 64'(expire), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      model_reset();
      repeat (30) begin
         cyc();
         chk("t6_no_expire", 64'(expire), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
